systolic_sequencer: RTL and testbench

//  Controller for the NxN bit-level systolic array. Accepts a job (pair count K, OR/XOR mode) and a

---
 rtl/systolic_pkg.sv | 38 +++
 rtl/systolic_sequencer_seq_result_buf.sv | 74 +++++++
 rtl/systolic_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_systolic_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array sequencer.
//  - state_e       : sequencer FSM states
//  - N_DEF/KW_DEF  : default array dimension and job-length width
//  - FLUSH_CYCLES  : pipeline drain length for the default array (2*N-1)
//  - READ_CYCLES   : readout length for the default array (N+1)
//  - flush_cycles()/read_cycles() : the same lengths for any array size
// -----------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    FLUSH = 3'd3,
    READ  = 3'd4,
    EMIT  = 3'd5
  } state_e;

  localparam int N_DEF  = 8;
  localparam int KW_DEF = 8;

  // The last operand enters at row/column 0 and needs 2N-1 shifts to leave
  // the far corner, so this many zero beats fully drain the array.
  localparam int FLUSH_CYCLES = 2 * N_DEF - 1;
  // One extra readout beat because the array's readout output is registered.
  localparam int READ_CYCLES  = N_DEF + 1;

  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int read_cycles(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/systolic_sequencer_seq_result_buf.sv
// -----------------------------------------------------------------------------
// seq_result_buf
// N x N-bit capture buffer for array readout rows, drained over valid/ready.
// Ports:
//  clk, reset        clock, synchronous active-high reset
//  wr_en_i           capture wr_data_i into entry wr_idx_i
//  wr_idx_i          capture index
//  wr_data_i         row from the array readout
//  emit_start_i      all rows captured: start presenting entry 0
//  res_data_o        current entry (held while res_valid_o & !res_ready_i)
//  res_valid_o       res_data_o valid
//  res_ready_i       downstream accepts res_data_o
//  last_hs_o         handshake on the final (N-1) entry this cycle
// -----------------------------------------------------------------------------
module seq_result_buf #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [N-1:0]  wr_data_i,
  input  logic          emit_start_i,
  output logic [N-1:0]  res_data_o,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic          last_hs_o
);

  logic [N-1:0]  rbuf_q [N];
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          hs;

  // Storage is not reset: every job rewrites all N entries during readout
  // before the output stage is armed, so stale rows are never presented.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      rbuf_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign hs        = valid_q & res_ready_i;
  assign last_hs_o = hs & (idx_q == IW'(N - 1));

  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    if (emit_start_i) begin
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (last_hs_o) begin
      idx_d   = '0;
      valid_d = 1'b0;
    end else if (hs) begin
      idx_d = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign res_valid_o = valid_q;
  assign res_data_o  = rbuf_q[idx_q];

endmodule

// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
// Job controller for the NxN bit-level systolic array: clear -> load operand
// pairs -> flush -> readout -> return N result rows over valid/ready.
// Ports:
//  clk, reset             clock, synchronous active-high reset
//  start/k_len/use_xor    job request (accepted in IDLE only)
//  busy, done             status; done pulses after the last result handshake
//  in_data/valid/ready    operand byte stream A,B,A,B,...
//  res_data/valid/ready   result rows, array row N-1 first
//  sa_*                   array control/operand outputs, sa_out readout input
//  stall_cnt              LOAD cycles starved of input
// Configuration macro: SEQ_STALL_CNT_EN builds the saturating stall counter;
// without it stall_cnt is tied to zero.
// -----------------------------------------------------------------------------
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int KW = KW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          use_xor,
  output logic          busy,
  output logic          done,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  res_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          sa_reset,
  output logic [N-1:0]  sa_in1,
  output logic [N-1:0]  sa_in2,
  output logic          sa_valid,
  output logic          sa_readout,
  output logic          sa_usexor,
  input  logic [N-1:0]  sa_out,
  output logic [15:0]   stall_cnt
);

  localparam int FLUSH_LEN = flush_cycles(N);
  localparam int READ_LEN  = read_cycles(N);
  localparam int CW        = $clog2(2 * N + 1);
  localparam int IW        = (N > 1) ? $clog2(N) : 1;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] pair_q, pair_d;
  logic          xor_q, xor_d;
  logic          odd_q, odd_d;     // next accepted byte is B
  logic [7:0]    a_q, a_d;
  logic [CW-1:0] cyc_q, cyc_d;     // FLUSH / READ beat index
  logic          done_q;

  logic          sa_valid_c;
  logic [N-1:0]  sa_in1_c, sa_in2_c;
  logic          emit_start;
  logic          buf_wr_en;
  logic [IW-1:0] buf_wr_idx;
  logic          buf_last_hs;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pair_d     = pair_q;
    xor_d      = xor_q;
    odd_d      = odd_q;
    a_d        = a_q;
    cyc_d      = cyc_q;
    sa_valid_c = 1'b0;
    sa_in1_c   = '0;
    sa_in2_c   = '0;
    emit_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k_len;
          xor_d   = use_xor;
          pair_d  = '0;
          odd_d   = 1'b0;
          cyc_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = (k_q != '0) ? LOAD : FLUSH;
      end
      LOAD: begin
        if (in_valid) begin
          if (!odd_q) begin
            a_d   = in_data;
            odd_d = 1'b1;
          end else begin
            // B goes straight to the array alongside the held A.
            sa_valid_c = 1'b1;
            sa_in1_c   = N'(a_q);
            sa_in2_c   = N'(in_data);
            odd_d      = 1'b0;
            pair_d     = pair_q + KW'(1);
            // Compare against K-1 so the counter never needs to hold 2^KW.
            if (pair_q == k_q - KW'(1)) begin
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        sa_valid_c = 1'b1;
        cyc_d      = cyc_q + CW'(1);
        if (cyc_q == CW'(FLUSH_LEN - 1)) begin
          cyc_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == CW'(READ_LEN - 1)) begin
          cyc_d      = '0;
          emit_start = 1'b1;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (buf_last_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      pair_q  <= '0;
      xor_q   <= 1'b0;
      odd_q   <= 1'b0;
      a_q     <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pair_q  <= pair_d;
      xor_q   <= xor_d;
      odd_q   <= odd_d;
      a_q     <= a_d;
      cyc_q   <= cyc_d;
      done_q  <= buf_last_hs;
    end
  end

  // Readout output is registered in the array: beat r presents row N-r,
  // so beat 0 carries nothing useful and beats 1..N fill rbuf[0..N-1].
  assign buf_wr_en  = (state_q == READ) && (cyc_q != '0);
  assign buf_wr_idx = IW'(cyc_q - CW'(1));

  seq_result_buf #(
    .N  (N),
    .IW (IW)
  ) u_result_buf (
    .clk          (clk),
    .reset        (reset),
    .wr_en_i      (buf_wr_en),
    .wr_idx_i     (buf_wr_idx),
    .wr_data_i    (sa_out),
    .emit_start_i (emit_start),
    .res_data_o   (res_data),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .last_hs_o    (buf_last_hs)
  );

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign in_ready   = (state_q == LOAD);
  assign sa_reset   = reset | (state_q == CLEAR);
  assign sa_valid   = sa_valid_c;
  assign sa_in1     = sa_in1_c;
  assign sa_in2     = sa_in2_c;
  assign sa_readout = (state_q == READ);
  assign sa_usexor  = xor_q;

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if ((state_q == LOAD) && !in_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
module tb_systolic_sequencer;
  import systolic_pkg::*;

  localparam int N  = 8;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] k_len;
  logic          use_xor;
  logic          busy;
  logic          done;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  res_data;
  logic          res_valid;
  logic          res_ready;
  logic          sa_reset;
  logic [N-1:0]  sa_in1;
  logic [N-1:0]  sa_in2;
  logic          sa_valid;
  logic          sa_readout;
  logic          sa_usexor;
  logic [N-1:0]  sa_out;
  logic [15:0]   stall_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0]   byte_q [$];
  logic [N-1:0] exp_q  [$];
  int in_gap_pct  = 0;
  int res_gap_pct = 0;
  int feed_cnt    = 0;
  int stall_seen  = 0;
  int done_cnt    = 0;
  bit saw_in_ready = 1'b0;

  always #5 clk = ~clk;

  systolic_sequencer #(.N(N), .KW(KW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .k_len      (k_len),
    .use_xor    (use_xor),
    .busy       (busy),
    .done       (done),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .sa_reset   (sa_reset),
    .sa_in1     (sa_in1),
    .sa_in2     (sa_in2),
    .sa_valid   (sa_valid),
    .sa_readout (sa_readout),
    .sa_usexor  (sa_usexor),
    .sa_out     (sa_out),
    .stall_cnt  (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Behavioural NxN bit-level array: A bits move right along rows, B bits
  // move down columns, each cell ORs/XORs the product of what it holds.
  logic [N-1:0] a_m   [N];
  logic [N-1:0] b_m   [N];
  logic [N-1:0] acc_m [N];
  int rd_m;

  always @(posedge clk) begin
    if (sa_reset) begin
      for (int i = 0; i < N; i++) begin
        a_m[i]   <= '0;
        b_m[i]   <= '0;
        acc_m[i] <= '0;
      end
      sa_out <= '0;
      rd_m   <= 0;
    end else begin
      if (sa_valid) begin
        for (int i = 0; i < N; i++) begin
          acc_m[i] <= sa_usexor ? (acc_m[i] ^ (a_m[i] & b_m[i]))
                                : (acc_m[i] | (a_m[i] & b_m[i]));
          a_m[i]   <= {a_m[i][N-2:0], sa_in1[i]};
          if (i == 0) b_m[0] <= sa_in2;
          else        b_m[i] <= b_m[i-1];
        end
      end
      if (sa_readout) begin
        if (rd_m < N) sa_out <= acc_m[N-1-rd_m];
        rd_m <= rd_m + 1;
      end
    end
  end

  // Operand feeder: presents the head of byte_q, with optional random gaps.
  initial begin
    bit hs;
    in_valid = 1'b0;
    in_data  = 8'h00;
    forever begin
      @(negedge clk);
      hs = in_valid && in_ready;
      if (in_ready) saw_in_ready = 1'b1;
      if (in_ready && !in_valid) stall_seen++;
      @(posedge clk);
      #1;
      if (hs && byte_q.size() > 0) begin
        void'(byte_q.pop_front());
        feed_cnt++;
      end
      if (byte_q.size() > 0 && (in_gap_pct == 0 || $urandom_range(99) >= in_gap_pct)) begin
        in_valid = 1'b1;
        in_data  = byte_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
  end

  // Result backpressure.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      res_ready = (res_gap_pct == 0) || ($urandom_range(99) >= res_gap_pct);
    end
  end

  // Result monitor / scoreboard.
  initial begin
    bit stalled;
    bit exp_done;
    logic [N-1:0] held;
    logic [N-1:0] e;
    stalled  = 1'b0;
    exp_done = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled  = 1'b0;
        exp_done = 1'b0;
      end else begin
        if (done || exp_done) check("done_pulse", {31'd0, done}, {31'd0, exp_done});
        if (done) done_cnt++;
        exp_done = 1'b0;
        if (res_valid) begin
          if (stalled) check("res_hold", {24'd0, res_data}, {24'd0, held});
          if (res_ready) begin
            if (exp_q.size() == 0) begin
              tests++;
              assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL res_unexpected: observed row %0h, expected no output", res_data);
              end
            end else begin
              e = exp_q.pop_front();
              check("res_row", {24'd0, res_data}, {24'd0, e});
              if (exp_q.size() == 0) exp_done = 1'b1;
            end
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held    = res_data;
          end
        end
      end
    end
  end

  // rows: rbuf[0] in the most significant byte.
  task automatic run_job(input string name, input logic [KW-1:0] k, input logic x,
                         input logic [N*N-1:0] rows, input int igap, input int rgap,
                         input bit chk_lat);
    int lat;
    int t;
    in_gap_pct   = igap;
    res_gap_pct  = rgap;
    stall_seen   = 0;
    saw_in_ready = 1'b0;
    done_cnt     = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(rows[(N-1-i)*N +: N]);
    start   = 1'b1;
    k_len   = k;
    use_xor = x;
    @(posedge clk);
    #1;
    start   = 1'b0;
    k_len   = 8'($urandom);
    use_xor = ~x;
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    check({name, "_clear"}, {31'd0, sa_reset}, 32'd1);
    lat = 0;
    while (!res_valid && lat < 5000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (chk_lat) check({name, "_latency"}, lat, 1 + 2 * int'(k) + FLUSH_CYCLES + READ_CYCLES);
    check({name, "_usexor"}, {31'd0, sa_usexor}, {31'd0, x});
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    #1;
    check({name, "_finished"}, {31'd0, (t < 5000)}, 32'd1);
    check({name, "_done_cnt"}, done_cnt, 32'd1);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    if (k == '0) check({name, "_no_in_ready"}, {31'd0, saw_in_ready}, 32'd0);
`ifdef SEQ_STALL_CNT_EN
    check({name, "_stall_cnt"}, {16'd0, stall_cnt}, stall_seen);
`else
    check({name, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
`endif
    $display("[TB] job %s k=%0d xor=%0d latency=%0d", name, k, x, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    reset   = 1'b1;
    start   = 1'b0;
    k_len   = '0;
    use_xor = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_sa_valid", {31'd0, sa_valid}, 32'd0);
    check("rst_sa_readout", {31'd0, sa_readout}, 32'd0);
    check("rst_sa_reset", {31'd0, sa_reset}, 32'd1);
    check("rst_sa_in1", {24'd0, sa_in1}, 32'd0);
    check("rst_sa_in2", {24'd0, sa_in2}, 32'd0);
    check("rst_sa_usexor", {31'd0, sa_usexor}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_sa_reset", {31'd0, sa_reset}, 32'd0);

    // OR, K=1, FF/01 -> only row 0 bit 0.
    byte_q = '{8'hFF, 8'h01};
    run_job("or_ff01", 8'd1, 1'b0, 64'h00000000_00000001, 0, 0, 1'b1);

    // OR, K=1, FF/FF -> diagonal.
    byte_q = '{8'hFF, 8'hFF};
    run_job("or_ffff", 8'd1, 1'b0, 64'h80402010_08040201, 0, 0, 1'b1);

    // K=2, (01,01) twice: OR keeps the bit, XOR cancels it.
    byte_q = '{8'h01, 8'h01, 8'h01, 8'h01};
    run_job("or_k2", 8'd2, 1'b0, 64'h00000000_00000001, 0, 0, 1'b1);
    byte_q = '{8'h01, 8'h01, 8'h01, 8'h01};
    run_job("xor_k2", 8'd2, 1'b1, 64'h00000000_00000000, 0, 0, 1'b1);

    // K=0: no LOAD, all-zero rows; stray input must not be consumed.
    byte_q = '{8'hAA};
    base = feed_cnt;
    run_job("k0", 8'd0, 1'b0, 64'h00000000_00000000, 0, 0, 1'b1);
    check("k0_no_consume", feed_cnt - base, 32'd0);
    byte_q.delete();
    @(posedge clk);
    #1;

    // Random input gaps and output backpressure.
    byte_q = '{8'hFF, 8'hFF};
    run_job("gaps_or", 8'd1, 1'b0, 64'h80402010_08040201, 30, 50, 1'b0);
    byte_q = '{8'hFF, 8'hFF};
    run_job("gaps_xor", 8'd1, 1'b1, 64'h80402010_08040201, 30, 50, 1'b0);

    // Reset mid-LOAD after three bytes, then a fresh FF/01 job.
    in_gap_pct  = 0;
    res_gap_pct = 0;
    byte_q = '{8'hFF, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h01};
    base = feed_cnt;
    start = 1'b1;
    k_len = 8'd4;
    use_xor = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (feed_cnt < base + 3 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("abort_three_bytes", feed_cnt - base, 32'd3);
    reset = 1'b1;
    #1;
    check("abort_sa_reset", {31'd0, sa_reset}, 32'd1);
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    byte_q.delete();
    reset = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] job abort reset applied after %0d bytes", feed_cnt - base);
    byte_q = '{8'hFF, 8'h01};
    run_job("after_abort", 8'd1, 1'b0, 64'h00000000_00000001, 0, 0, 1'b1);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
